// File: rtl/norm_round_stage_pkg.sv
// Shared constants for the normalize/round stage: rounding mode and flag layout.
package norm_round_stage_pkg;

  // Only round-to-nearest-even is implemented; the enum leaves room for more modes.
  typedef enum logic [0:0] {
    RND_RNE = 1'b0
  } rnd_mode_e;

  localparam rnd_mode_e RND_MODE = RND_RNE;

  // Bit positions inside the packed result-flag vector.
  localparam int unsigned FLAG_W     = 3;
  localparam int unsigned FLAG_ZERO  = 0;
  localparam int unsigned FLAG_UFLOW = 1;
  localparam int unsigned FLAG_OFLOW = 2;

  // Round-to-nearest-even increment decision from guard, sticky and kept LSB.
  function automatic logic rne_round_up(input logic guard, input logic sticky,
                                        input logic lsb);
    return guard & (sticky | lsb);
  endfunction

endpackage

// File: rtl/norm_round_stage_flo.sv
// Leading-one finder: bit index of the most significant set bit of mant_i.
module flo #(
  parameter int unsigned N   = 32,
  parameter int unsigned E_W = 8,
  localparam int unsigned LZW   = $clog2(N),
  localparam int unsigned OFF_W = (E_W > LZW) ? E_W : LZW
) (
  input  logic [N-1:0]     mant_i,
  output logic [OFF_W-1:0] offset_o,
  output logic             found_o
);

  // Scan upward so the highest set bit is the last one written.
  always_comb begin
    offset_o = '0;
    found_o  = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (mant_i[i]) begin
        offset_o = OFF_W'(i);
        found_o  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/norm_round_stage.sv
// Two-stage normalize and round-to-nearest-even pipeline with valid/ready flow control.
module norm_round_stage
  import norm_round_stage_pkg::*;
#(
  parameter int unsigned N   = 32,
  parameter int unsigned E_W = 8,
  parameter int unsigned M_W = 24
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N-1:0]   in_mant,
  input  logic [E_W-1:0] in_exp,
  input  logic           in_sign,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [M_W-1:0] out_mant,
  output logic [E_W-1:0] out_exp,
  output logic           out_sign,
  output logic           out_zero,
  output logic           out_uflow,
  output logic           out_oflow
);

  localparam int unsigned LZW   = $clog2(N);
  localparam int unsigned OFF_W = (E_W > LZW) ? E_W : LZW;
  // Ones over the bits below the guard position (empty when M_W == N-1).
  localparam logic [N-1:0] STICKY_MASK = {N{1'b1}} >> (M_W + 1);

  // Leading-one search on the incoming mantissa.
  logic [OFF_W-1:0] flo_offset;
  logic             flo_found;

  flo #(
    .N  (N),
    .E_W(E_W)
  ) u_flo (
    .mant_i  (in_mant),
    .offset_o(flo_offset),
    .found_o (flo_found)
  );

  // Stage 1 registers.
  logic           s1_valid_q, s1_valid_d;
  logic [N-1:0]   s1_mant_q, s1_mant_d;
  logic [E_W-1:0] s1_exp_q, s1_exp_d;
  logic           s1_sign_q, s1_sign_d;
  logic [LZW-1:0] s1_lz_q, s1_lz_d;
  logic           s1_zero_q, s1_zero_d;

  // Stage 2 (output) registers.
  logic              out_valid_q, out_valid_d;
  logic [M_W-1:0]    out_mant_q, out_mant_d;
  logic [E_W-1:0]    out_exp_q, out_exp_d;
  logic              out_sign_q, out_sign_d;
  logic [FLAG_W-1:0] out_flags_q, out_flags_d;

  logic s1_load_c;
  logic s2_load_c;

  // Each stage loads when empty or when its consumer drains it this cycle.
  always_comb begin
    s2_load_c = !out_valid_q || out_ready;
    s1_load_c = !s1_valid_q || s2_load_c;
    in_ready  = s1_load_c;
  end

  // Stage 1 next state: capture input and leading-zero count.
  always_comb begin
    s1_valid_d = in_valid;
    s1_mant_d  = in_mant;
    s1_exp_d   = in_exp;
    s1_sign_d  = in_sign;
    s1_lz_d    = LZW'(OFF_W'(N - 1) - flo_offset);
    s1_zero_d  = !flo_found;
  end

  // Stage 1 register; valid clears on bubbles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_mant_q  <= '0;
      s1_exp_q   <= '0;
      s1_sign_q  <= 1'b0;
      s1_lz_q    <= '0;
      s1_zero_q  <= 1'b0;
    end else if (s1_load_c) begin
      s1_valid_q <= s1_valid_d;
      s1_mant_q  <= s1_mant_d;
      s1_exp_q   <= s1_exp_d;
      s1_sign_q  <= s1_sign_d;
      s1_lz_q    <= s1_lz_d;
      s1_zero_q  <= s1_zero_d;
    end
  end

  // Stage 2 datapath signals.
  logic [N-1:0]   sh_c;
  logic [M_W-1:0] kept_c;
  logic           guard_c;
  logic           sticky_c;
  logic           inc_c;
  logic [M_W:0]   rounded_c;
  logic [E_W-1:0] exp_base_c;
  logic           uflow_c;

  // Normalize, round and classify the stage-1 item.
  always_comb begin
    sh_c       = s1_mant_q << s1_lz_q;
    kept_c     = sh_c[N-1 -: M_W];
    guard_c    = sh_c[N-1-M_W];
    sticky_c   = |(sh_c & STICKY_MASK);
    inc_c      = (RND_MODE == RND_RNE) ? rne_round_up(guard_c, sticky_c, kept_c[0]) : 1'b0;
    rounded_c  = {1'b0, kept_c} + (M_W + 1)'(inc_c);
    uflow_c    = OFF_W'(s1_lz_q) > OFF_W'(s1_exp_q);
    exp_base_c = E_W'(OFF_W'(s1_exp_q) - OFF_W'(s1_lz_q));

    out_valid_d = s1_valid_q;
    out_sign_d  = s1_sign_q;
    out_mant_d  = '0;
    out_exp_d   = '0;
    out_flags_d = '0;

    if (s1_zero_q) begin
      out_flags_d[FLAG_ZERO] = 1'b1;
    end else if (uflow_c) begin
      // Flush to zero when the exponent cannot absorb the normalization shift.
      out_flags_d[FLAG_ZERO]  = 1'b1;
      out_flags_d[FLAG_UFLOW] = 1'b1;
    end else if (rounded_c[M_W]) begin
      if (&exp_base_c) begin
        // Rounding carry pushes the exponent past its maximum: saturate.
        out_flags_d[FLAG_OFLOW] = 1'b1;
        out_mant_d              = '1;
        out_exp_d               = '1;
      end else begin
        out_mant_d = {1'b1, {(M_W - 1){1'b0}}};
        out_exp_d  = E_W'(exp_base_c + E_W'(1));
      end
    end else begin
      out_mant_d = rounded_c[M_W-1:0];
      out_exp_d  = exp_base_c;
    end
  end

  // Output register; holds while stalled by the consumer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_mant_q  <= '0;
      out_exp_q   <= '0;
      out_sign_q  <= 1'b0;
      out_flags_q <= '0;
    end else if (s2_load_c) begin
      out_valid_q <= out_valid_d;
      out_mant_q  <= out_mant_d;
      out_exp_q   <= out_exp_d;
      out_sign_q  <= out_sign_d;
      out_flags_q <= out_flags_d;
    end
  end

  // Drive ports from the output register.
  always_comb begin
    out_valid = out_valid_q;
    out_mant  = out_mant_q;
    out_exp   = out_exp_q;
    out_sign  = out_sign_q;
    out_zero  = out_flags_q[FLAG_ZERO];
    out_uflow = out_flags_q[FLAG_UFLOW];
    out_oflow = out_flags_q[FLAG_OFLOW];
  end

endmodule

// File: tb/tb_norm_round_stage.sv
// Self-checking bench for norm_round_stage (N=32, E_W=8, M_W=24).
module tb_norm_round_stage;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_mant;
  logic [7:0]  in_exp;
  logic        in_sign;
  logic        out_valid;
  logic        out_ready;
  logic [23:0] out_mant;
  logic [7:0]  out_exp;
  logic        out_sign;
  logic        out_zero;
  logic        out_uflow;
  logic        out_oflow;

  norm_round_stage #(.N(32), .E_W(8), .M_W(24)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_mant  (in_mant),
    .in_exp   (in_exp),
    .in_sign  (in_sign),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_mant (out_mant),
    .out_exp  (out_exp),
    .out_sign (out_sign),
    .out_zero (out_zero),
    .out_uflow(out_uflow),
    .out_oflow(out_oflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [23:0] mant;
    logic [7:0]  exp;
    logic        sign;
    logic        zero;
    logic        uflow;
    logic        oflow;
  } res_t;

  typedef struct {
    logic [31:0] mant;
    logic [7:0]  exp;
    logic        sign;
    res_t        want;
  } vec_t;

  int   tests = 0;
  int   fails = 0;
  res_t exp_q[$];
  int   n_acc;
  logic hold_chk;
  res_t held;

  // Reference: value-level normalize plus nearest-even on the discarded remainder.
  function automatic res_t ref_model(input logic [31:0] m, input logic [7:0] e, input logic s);
    res_t r;
    int p;
    int lz;
    int ex;
    longint unsigned v;
    longint unsigned kept;
    longint unsigned rem;
    r = '0;
    r.sign = s;
    if (m == 32'd0) begin
      r.zero = 1'b1;
      return r;
    end
    p = 31;
    while (m[p] == 1'b0) p--;
    lz = 31 - p;
    if (lz > int'(e)) begin
      r.zero  = 1'b1;
      r.uflow = 1'b1;
      return r;
    end
    v    = 64'(m) << lz;
    kept = v / 256;
    rem  = v % 256;
    if (rem > 128 || (rem == 128 && kept % 2 == 1)) kept++;
    ex = int'(e) - lz;
    if (kept == 64'h1000000) begin
      kept = 64'h800000;
      ex++;
    end
    if (ex > 255) begin
      r.oflow = 1'b1;
      r.mant  = '1;
      r.exp   = '1;
    end else begin
      r.mant = 24'(kept);
      r.exp  = 8'(ex);
    end
    return r;
  endfunction

  function automatic res_t dut_out();
    res_t r;
    r = {out_mant, out_exp, out_sign, out_zero, out_uflow, out_oflow};
    return r;
  endfunction

  task automatic check_res(input string name, input res_t act, input res_t want);
    tests++;
    if (act !== want) begin
      fails++;
      $display("FAIL %s: got mant=%h exp=%h s=%b z=%b u=%b o=%b, required mant=%h exp=%h s=%b z=%b u=%b o=%b",
               name, act.mant, act.exp, act.sign, act.zero, act.uflow, act.oflow,
               want.mant, want.exp, want.sign, want.zero, want.uflow, want.oflow);
    end
  endtask

  task automatic check_int(input string name, input int act, input int want);
    tests++;
    if (act != want) begin
      fails++;
      $display("FAIL %s: got %0d, required %0d", name, act, want);
    end
  endtask

  // One streaming cycle: drive at negedge, score outputs and log accepted inputs.
  task automatic cycle(input logic iv, input logic [31:0] m, input logic [7:0] e,
                       input logic s, input logic ordy);
    res_t cur;
    @(negedge clk);
    in_valid  = iv;
    in_mant   = m;
    in_exp    = e;
    in_sign   = s;
    out_ready = ordy;
    #1;
    cur = dut_out();
    if (hold_chk) check_res("hold_stable", cur, held);
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_output: got mant=%h exp=%h, required no output", cur.mant, cur.exp);
      end else begin
        check_res("stream", cur, exp_q.pop_front());
      end
    end
    hold_chk = out_valid && !out_ready;
    held     = cur;
    if (in_valid && in_ready) begin
      exp_q.push_back(ref_model(m, e, s));
      n_acc++;
    end
  endtask

  // Single item through an empty pipe with out_ready held high; checks latency too.
  task automatic run_vec(input vec_t v, input string name);
    int lat;
    @(negedge clk);
    in_valid  = 1'b1;
    in_mant   = v.mant;
    in_exp    = v.exp;
    in_sign   = v.sign;
    out_ready = 1'b1;
    #1;
    check_int({name, "_in_ready"}, int'(in_ready), 1);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    lat = 1;
    while (!out_valid && lat < 6) begin
      @(negedge clk);
      #1;
      lat++;
    end
    check_int({name, "_latency"}, lat, 2);
    check_res(name, dut_out(), v.want);
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 8 && exp_q.size() != 0; i++) cycle(1'b0, 32'd0, 8'd0, 1'b0, 1'b1);
    check_int({name, "_outstanding"}, exp_q.size(), 0);
  endtask

  vec_t vecs[10];
  logic [31:0] bp_mant[4];

  initial begin
    vecs[0] = '{32'h00000001, 8'd100, 1'b0, '{24'h800000, 8'd69,  1'b0, 1'b0, 1'b0, 1'b0}};
    vecs[1] = '{32'hFFFFFFFF, 8'd10,  1'b1, '{24'h800000, 8'd11,  1'b1, 1'b0, 1'b0, 1'b0}};
    vecs[2] = '{32'h80000080, 8'd50,  1'b0, '{24'h800000, 8'd50,  1'b0, 1'b0, 1'b0, 1'b0}};
    vecs[3] = '{32'h80000180, 8'd50,  1'b0, '{24'h800002, 8'd50,  1'b0, 1'b0, 1'b0, 1'b0}};
    vecs[4] = '{32'h00000000, 8'd7,   1'b0, '{24'h000000, 8'd0,   1'b0, 1'b1, 1'b0, 1'b0}};
    vecs[5] = '{32'h00001000, 8'd5,   1'b0, '{24'h000000, 8'd0,   1'b0, 1'b1, 1'b1, 1'b0}};
    vecs[6] = '{32'hFFFFFFFF, 8'd255, 1'b0, '{24'hFFFFFF, 8'hFF,  1'b0, 1'b0, 1'b0, 1'b1}};
    vecs[7] = '{32'h00001000, 8'd19,  1'b1, '{24'h800000, 8'd0,   1'b1, 1'b0, 1'b0, 1'b0}};
    vecs[8] = '{32'h80000081, 8'd50,  1'b0, '{24'h800001, 8'd50,  1'b0, 1'b0, 1'b0, 1'b0}};
    vecs[9] = '{32'hFFFFFFFF, 8'd254, 1'b0, '{24'h800000, 8'd255, 1'b0, 1'b0, 1'b0, 1'b0}};
    bp_mant[0] = 32'h00000003;
    bp_mant[1] = 32'h12345678;
    bp_mant[2] = 32'h80000180;
    bp_mant[3] = 32'h0000FFFF;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_mant   = '0;
    in_exp    = '0;
    in_sign   = 1'b0;
    out_ready = 1'b0;
    hold_chk  = 1'b0;
    held      = '0;
    n_acc     = 0;

    #3;
    check_int("reset_out_valid", int'(out_valid), 0);
    check_int("reset_in_ready", int'(in_ready), 1);
    check_res("reset_outputs", dut_out(), '0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed corner vectors.
    for (int i = 0; i < 10; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Backpressure: consumer stalled while four items are offered back to back.
    n_acc = 0;
    for (int i = 0; i < 6; i++) cycle(1'b1, bp_mant[n_acc], 8'd40, 1'b0, 1'b0);
    check_int("bp_accepts_while_stalled", n_acc, 2);
    check_int("bp_in_ready_low", int'(in_ready), 0);
    for (int i = 0; i < 10 && n_acc < 4; i++)
      cycle(n_acc < 4, bp_mant[n_acc < 4 ? n_acc : 0], 8'd40, 1'b0, 1'b1);
    check_int("bp_all_accepted", n_acc, 4);
    drain("bp");

    // Randomized traffic with random backpressure.
    for (int i = 0; i < 600; i++) begin
      logic [31:0] m;
      logic [7:0]  e;
      int          mode;
      mode = int'($urandom_range(0, 4));
      m    = $urandom;
      case (mode)
        0:       m = m >> $urandom_range(0, 31);
        1:       m = 32'd0;
        2:       m = (m | 32'h80000000) & 32'hFFFFFF80 | 32'h00000080;
        default: ;
      endcase
      e = 8'($urandom_range(0, 255));
      cycle($urandom_range(0, 9) < 7, m, e, 1'($urandom), $urandom_range(0, 9) < 7);
    end
    drain("random");

    // Reset in the middle of traffic must discard in-flight items at once.
    for (int i = 0; i < 3; i++) cycle(1'b1, 32'h00F00000 + 32'(i), 8'd60, 1'b0, 1'b0);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_int("midreset_out_valid", int'(out_valid), 0);
    check_int("midreset_in_ready", int'(in_ready), 1);
    check_res("midreset_outputs", dut_out(), '0);
    exp_q.delete();
    hold_chk = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    run_vec(vecs[3], "post_reset");
    for (int i = 0; i < 3; i++) cycle(1'b0, 32'd0, 8'd0, 1'b0, 1'b1);
    check_int("post_reset_idle", int'(out_valid), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Global watchdog so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

endmodule
